// File: rtl/cpu_seq.sv
// Multi-cycle instruction sequencer: steps IF->ID->EX->(MEM)->WB with req/ack
// handshakes to ROM/RAM, cycle/retire counters, ack timeout error and halt.
module cpu_seq #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned INST_WIDTH     = 32,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst_n,
  input  logic [ADDR_WIDTH-1:0] i_ifu_pc,
  output logic                  o_ifu_pc_en,
  output logic                  o_rom_rd_req,
  output logic [ADDR_WIDTH-1:0] o_rom_rd_addr,
  input  logic                  i_rom_rd_ack,
  input  logic [INST_WIDTH-1:0] i_rom_rd_data,
  output logic [INST_WIDTH-1:0] o_inst,
  input  logic                  i_idu_ram_rd,
  input  logic                  i_idu_ram_wr,
  input  logic                  i_idu_reg_wr,
  output logic                  o_ram_req,
  output logic                  o_ram_wr_en,
  input  logic                  i_ram_ack,
  input  logic [DATA_WIDTH-1:0] i_ram_rd_data,
  output logic [DATA_WIDTH-1:0] o_lsu_rd_data,
  output logic                  o_gpr_wr_en,
  input  logic                  i_halt,
  output logic                  o_retire,
  output logic [CNT_WIDTH-1:0]  o_cycle,
  output logic [CNT_WIDTH-1:0]  o_instret,
  output logic                  o_err,
  output logic [2:0]            o_state
);

  localparam int unsigned WW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6,
    S_ERR  = 3'd7
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] rom_addr_q;
  logic [INST_WIDTH-1:0] inst_q;
  logic [DATA_WIDTH-1:0] lsu_q;
  logic [CNT_WIDTH-1:0]  cycle_q;
  logic [CNT_WIDTH-1:0]  instret_q;
  logic [WW-1:0]         wait_q;
  logic [WW-1:0]         wait_d;
  logic                  timeout_hit;
  logic                  active;

  always_comb begin
    wait_d      = wait_q + WW'(1);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_d == WW'(TIMEOUT_CYCLES));
    active      = (state_q == S_IF) || (state_q == S_ID) || (state_q == S_EX) ||
                  (state_q == S_MEM) || (state_q == S_WB);
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      inst_q     <= INST_WIDTH'(32'h0000_0013);
      lsu_q      <= '0;
      cycle_q    <= '0;
      instret_q  <= '0;
      wait_q     <= '0;
    end else begin
      if (active) cycle_q <= cycle_q + CNT_WIDTH'(1);
      case (state_q)
        S_IDLE: begin
          state_q    <= S_IF;
          rom_addr_q <= i_ifu_pc;
          wait_q     <= '0;
        end
        S_IF: begin
          if (i_rom_rd_ack) begin
            inst_q  <= i_rom_rd_data;
            state_q <= S_ID;
          end else if (timeout_hit) begin
            state_q <= S_ERR;
          end else if (TIMEOUT_CYCLES != 0) begin
            wait_q <= wait_d;
          end
        end
        S_ID: state_q <= S_EX;
        S_EX: begin
          if (i_idu_ram_rd || i_idu_ram_wr) begin
            state_q <= S_MEM;
            wait_q  <= '0;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (i_ram_ack) begin
            if (i_idu_ram_rd) lsu_q <= i_ram_rd_data;
            state_q <= S_WB;
          end else if (timeout_hit) begin
            state_q <= S_ERR;
          end else if (TIMEOUT_CYCLES != 0) begin
            wait_q <= wait_d;
          end
        end
        S_WB: begin
          instret_q <= instret_q + CNT_WIDTH'(1);
          if (i_halt) begin
            state_q <= S_HALT;
          end else begin
            state_q    <= S_IF;
            rom_addr_q <= i_ifu_pc;
            wait_q     <= '0;
          end
        end
        S_HALT:  state_q <= S_HALT;
        S_ERR:   state_q <= S_ERR;
        default: state_q <= S_ERR;
      endcase
    end
  end

  // Strobes are decoded from the registered state, so reset drops them immediately.
  assign o_rom_rd_req  = (state_q == S_IF);
  assign o_ram_req     = (state_q == S_MEM);
  assign o_ram_wr_en   = (state_q == S_MEM) && i_idu_ram_wr;
  assign o_gpr_wr_en   = (state_q == S_WB) && i_idu_reg_wr;
  assign o_ifu_pc_en   = (state_q == S_WB);
  assign o_retire      = (state_q == S_WB);
  assign o_err         = (state_q == S_ERR);
  assign o_state       = state_q;
  assign o_rom_rd_addr = rom_addr_q;
  assign o_inst        = inst_q;
  assign o_lsu_rd_data = lsu_q;
  assign o_cycle       = cycle_q;
  assign o_instret     = instret_q;

endmodule

// File: tb/tb_cpu_seq.sv
// Directed table-driven bench for cpu_seq (timeout shortened to 8 cycles).
module tb_cpu_seq;

  logic        i_sys_clk = 1'b0;
  logic        i_sys_rst_n;
  logic [31:0] i_ifu_pc;
  logic        o_ifu_pc_en;
  logic        o_rom_rd_req;
  logic [31:0] o_rom_rd_addr;
  logic        i_rom_rd_ack;
  logic [31:0] i_rom_rd_data;
  logic [31:0] o_inst;
  logic        i_idu_ram_rd;
  logic        i_idu_ram_wr;
  logic        i_idu_reg_wr;
  logic        o_ram_req;
  logic        o_ram_wr_en;
  logic        i_ram_ack;
  logic [31:0] i_ram_rd_data;
  logic [31:0] o_lsu_rd_data;
  logic        o_gpr_wr_en;
  logic        i_halt;
  logic        o_retire;
  logic [31:0] o_cycle;
  logic [31:0] o_instret;
  logic        o_err;
  logic [2:0]  o_state;

  int tests = 0;
  int fails = 0;

  cpu_seq #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .INST_WIDTH(32), .CNT_WIDTH(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .i_sys_clk(i_sys_clk), .i_sys_rst_n(i_sys_rst_n), .i_ifu_pc(i_ifu_pc),
    .o_ifu_pc_en(o_ifu_pc_en), .o_rom_rd_req(o_rom_rd_req), .o_rom_rd_addr(o_rom_rd_addr),
    .i_rom_rd_ack(i_rom_rd_ack), .i_rom_rd_data(i_rom_rd_data), .o_inst(o_inst),
    .i_idu_ram_rd(i_idu_ram_rd), .i_idu_ram_wr(i_idu_ram_wr), .i_idu_reg_wr(i_idu_reg_wr),
    .o_ram_req(o_ram_req), .o_ram_wr_en(o_ram_wr_en), .i_ram_ack(i_ram_ack),
    .i_ram_rd_data(i_ram_rd_data), .o_lsu_rd_data(o_lsu_rd_data), .o_gpr_wr_en(o_gpr_wr_en),
    .i_halt(i_halt), .o_retire(o_retire), .o_cycle(o_cycle), .o_instret(o_instret),
    .o_err(o_err), .o_state(o_state)
  );

  always #5 i_sys_clk = ~i_sys_clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic        rw;
    int          rom_wait;
    int          ram_wait;
    logic [31:0] inst;
    logic [31:0] rdata;
    logic [31:0] pc;
    int          exp_retire;
    int          exp_nreq;
    int          exp_nwr;
    int          exp_ngpr;
    logic [31:0] exp_lsu;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_sys_clk);
    #1;
  endtask

  // Entered in the first IF cycle; leaves in the cycle after WB.
  task automatic run_vec(input vec_t v, input logic [31:0] next_pc);
    int cyc = 1;
    int retire_at = 0;
    int nreq = 0, nwr = 0, ngpr = 0, npc = 0, nbad = 0;
    int rw = 0, mw = 0;
    logic [31:0] addr0, lsu_wb, instret0;
    instret0      = o_instret;
    addr0         = o_rom_rd_addr;
    i_idu_ram_rd  = v.ld;
    i_idu_ram_wr  = v.st;
    i_idu_reg_wr  = v.rw;
    i_rom_rd_data = v.inst;
    i_ram_rd_data = v.rdata;
    lsu_wb        = '0;
    for (int k = 0; k < 40 && retire_at == 0; k++) begin
      i_rom_rd_ack = (o_state == 3'd1) && (rw == v.rom_wait);
      i_ram_ack    = (o_state == 3'd4) && (mw == v.ram_wait);
      #1;
      if (o_state == 3'd1) rw++;
      if (o_state == 3'd4) mw++;
      if (o_ram_req) nreq++;
      if (o_ram_wr_en) nwr++;
      if (o_ram_wr_en && !o_ram_req) nbad++;
      if (o_gpr_wr_en) ngpr++;
      if (o_ifu_pc_en) npc++;
      if (o_retire) begin
        retire_at = cyc;
        lsu_wb    = o_lsu_rd_data;
        i_ifu_pc  = next_pc;
      end
      step();
      cyc++;
    end
    i_rom_rd_ack = 1'b0;
    i_ram_ack    = 1'b0;
    check("fetch_addr", addr0, v.pc);
    check("retire_cycle", retire_at, v.exp_retire);
    check("ram_req_cycles", nreq, v.exp_nreq);
    check("ram_wr_cycles", nwr, v.exp_nwr);
    check("wr_without_req", nbad, 0);
    check("gpr_wr_cycles", ngpr, v.exp_ngpr);
    check("pc_en_cycles", npc, 1);
    check("lsu_in_wb", lsu_wb, v.exp_lsu);
    check("inst_latched", o_inst, v.inst);
    check("instret_inc", o_instret, instret0 + 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t hv;
    logic [31:0] cyc_snap;
    //            ld st rw rw_ ra_ inst          rdata         pc         ret nrq nwr gpr lsu
    vecs[0] = '{1'b0, 1'b0, 1'b1, 0, 0, 32'h0010_0093, 32'h0,        32'h0000_0100, 4, 0, 0, 1, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 0, 3, 32'h0000_A103, 32'hDEAD_BEEF, 32'h0000_0104, 8, 4, 0, 1, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 0, 1, 32'h0020_A023, 32'h5555_5555, 32'h0000_0108, 6, 2, 2, 0, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 2, 0, 32'h0030_8193, 32'h0,        32'h0000_010C, 6, 0, 0, 1, 32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1, 0, 32'h0040_A203, 32'h1234_5678, 32'h0000_0110, 6, 1, 0, 1, 32'h1234_5678};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_0463, 32'h0,        32'h0000_0114, 4, 0, 0, 0, 32'h1234_5678};
    hv      = '{1'b0, 1'b0, 1'b1, 0, 0, 32'h0010_0073, 32'h0,        32'h0000_0118, 4, 0, 0, 1, 32'h1234_5678};

    i_sys_rst_n = 1'b0; i_ifu_pc = vecs[0].pc; i_rom_rd_ack = 1'b0; i_rom_rd_data = '0;
    i_idu_ram_rd = 1'b0; i_idu_ram_wr = 1'b0; i_idu_reg_wr = 1'b0; i_ram_ack = 1'b0;
    i_ram_rd_data = '0; i_halt = 1'b0;
    #23;
    check("rst_state", o_state, 3'd0);
    check("rst_inst", o_inst, 32'h0000_0013);
    check("rst_rom_req", o_rom_rd_req, 1'b0);
    check("rst_cycle", o_cycle, 32'd0);
    @(posedge i_sys_clk); #1;
    i_sys_rst_n = 1'b1;
    step();
    check("idle_to_if", o_state, 3'd1);

    for (int i = 0; i < 6; i++)
      run_vec(vecs[i], (i < 5) ? vecs[i+1].pc : hv.pc);
    check("cycle_total", o_cycle, 32'd34);
    check("instret_total", o_instret, 32'd6);

    // Halt requested while in WB.
    i_halt = 1'b1;
    run_vec(hv, 32'h0000_011C);
    check("halt_state", o_state, 3'd6);
    check("halt_cycle", o_cycle, 32'd38);
    check("halt_instret", o_instret, 32'd7);
    i_rom_rd_ack = 1'b1; i_ram_ack = 1'b1;
    for (int k = 0; k < 4; k++) step();
    check("halt_no_rom_req", o_rom_rd_req, 1'b0);
    check("halt_no_ram_req", o_ram_req, 1'b0);
    check("halt_frozen_cycle", o_cycle, 32'd38);
    check("halt_stays", o_state, 3'd6);
    i_rom_rd_ack = 1'b0; i_ram_ack = 1'b0; i_halt = 1'b0;

    // Reset asserted while a load waits in MEM.
    i_sys_rst_n = 1'b0; #2; i_sys_rst_n = 1'b1;
    step();
    i_ifu_pc = 32'h0000_0200; i_idu_ram_rd = 1'b1; i_idu_reg_wr = 1'b1;
    check("rst2_if", o_state, 3'd1);
    i_rom_rd_ack = 1'b1; i_rom_rd_data = 32'h0000_2283;
    step(); i_rom_rd_ack = 1'b0;
    step(); step(); step();
    check("mem_wait_state", o_state, 3'd4);
    check("mem_wait_req", o_ram_req, 1'b1);
    #3; i_sys_rst_n = 1'b0; #1;
    check("async_rst_req", o_ram_req, 1'b0);
    check("async_rst_state", o_state, 3'd0);
    check("async_rst_cycle", o_cycle, 32'd0);
    check("async_rst_instret", o_instret, 32'd0);
    check("async_rst_inst", o_inst, 32'h0000_0013);
    check("async_rst_lsu", o_lsu_rd_data, 32'd0);
    i_ifu_pc = 32'h0000_0300; i_idu_ram_rd = 1'b0;
    @(negedge i_sys_clk); i_sys_rst_n = 1'b1; #1;
    check("rel_idle", o_state, 3'd0);
    step();
    check("rel_if", o_state, 3'd1);
    check("rel_fetch_addr", o_rom_rd_addr, 32'h0000_0300);

    // ROM never acks: ERR after 8 IF cycles.
    for (int k = 0; k < 7; k++) step();
    check("if_cycle8_state", o_state, 3'd1);
    check("if_cycle8_req", o_rom_rd_req, 1'b1);
    step();
    check("to_state", o_state, 3'd7);
    check("to_err", o_err, 1'b1);
    check("to_req", o_rom_rd_req, 1'b0);
    cyc_snap = o_cycle;
    check("to_cycle_count", cyc_snap, 32'd8);
    i_rom_rd_ack = 1'b1;
    for (int k = 0; k < 3; k++) step();
    i_rom_rd_ack = 1'b0;
    check("late_ack_state", o_state, 3'd7);
    check("late_ack_err", o_err, 1'b1);
    check("late_ack_req", o_rom_rd_req, 1'b0);
    check("err_cycle_frozen", o_cycle, cyc_snap);
    check("err_inst_kept", o_inst, 32'h0000_0013);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
